// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int MEM_BYTES_DEF = 5000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Load extension and read-modify-write store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] rdata_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] ext_o,
  output logic [63:0] merge_o
);

  logic sx;
  assign sx = !unsigned_i;

  always_comb begin
    ext_o   = rdata_i;
    merge_o = wdata_i;
    unique case (size_i)
      SZ_B: begin
        ext_o   = {{56{sx & rdata_i[7]}}, rdata_i[7:0]};
        merge_o = {rdata_i[63:8], wdata_i[7:0]};
      end
      SZ_H: begin
        ext_o   = {{48{sx & rdata_i[15]}}, rdata_i[15:0]};
        merge_o = {rdata_i[63:16], wdata_i[15:0]};
      end
      SZ_W: begin
        ext_o   = {{32{sx & rdata_i[31]}}, rdata_i[31:0]};
        merge_o = {rdata_i[63:32], wdata_i[31:0]};
      end
      SZ_D: begin
        ext_o   = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request FSM, range check and 64-bit RAM access.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic        mem_wen_o,
  input  logic [63:0] mem_rdata_i
);

  localparam logic [63:0] LIMIT = 64'(MEM_BYTES - 8);

  state_e      state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;
  logic [63:0] wdata_q;
  logic        ready_q;
  logic        rvalid_q;
  logic        rerr_q;
  logic [63:0] rdata_q;
  logic [63:0] maddr_q;
  logic [63:0] mwdata_q;
  logic        wen_q;

  logic [63:0] ext;
  logic [63:0] merge;

  lsu_align u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdata_i    (mem_rdata_i),
    .wdata_i    (wdata_q),
    .ext_o      (ext),
    .merge_o    (merge)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      wen_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            wdata_q <= req_wdata_i;
            err_q   <= req_addr_i > LIMIT;
            maddr_q <= req_addr_i;
            ready_q <= 1'b0;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (err_q || !we_q) begin
            rdata_q  <= err_q ? 64'd0 : ext;
            rerr_q   <= err_q;
            rvalid_q <= 1'b1;
            state_q  <= S_RESP;
          end else begin
            mwdata_q <= merge;
            wen_q    <= 1'b1;
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          wen_q    <= 1'b0;
          rdata_q  <= '0;
          rerr_q   <= 1'b0;
          rvalid_q <= 1'b1;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          rvalid_q <= 1'b0;
          rerr_q   <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  // Write enable is gated by reset so an interrupted store never lands.
  assign mem_wen_o    = wen_q & ~rst_i;
  assign req_ready_o  = ready_q;
  assign resp_valid_o = rvalid_q;
  assign resp_err_o   = rerr_q;
  assign resp_rdata_o = rdata_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wdata_o  = mwdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a byte-addressed RAM model.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wen;
  logic [63:0] mem_rdata;

  logic [7:0] ram [0:8191];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu #(.MEM_BYTES(5000)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_wen_o      (mem_wen),
    .mem_rdata_i    (mem_rdata)
  );

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      mem_rdata[8*i +: 8] = ram[mem_addr[12:0] + 13'(i)];
  end

  always @(posedge clk) begin
    if (mem_wen)
      for (int i = 0; i < 8; i++)
        ram[mem_addr[12:0] + 13'(i)] = mem_wdata[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and follow it to its response.
  task automatic xact(input logic we, input logic [1:0] sz,
                      input logic uns, input logic [63:0] a,
                      input logic [63:0] wd, output int lat,
                      output int wen_at, output int wen_n,
                      output logic [63:0] rd, output logic er);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_uns   = uns;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    wen_at = -1;
    wen_n = 0;
    rd = 'x;
    er = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_wen) begin
        wen_n++;
        wen_at = c;
      end
      if (resp_valid) begin
        lat = c;
        rd = resp_rdata;
        er = resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  int lat, wen_at, wen_n;
  logic [63:0] rd;
  logic er;

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    ram[4808] = 8'hff; ram[4809] = 8'hff;
    ram[4810] = 8'hff; ram[4811] = 8'hff;
    ram[4812] = 8'h32; ram[4816] = 8'h0a;
    ram[4828] = 8'hba; ram[4829] = 8'hff;
    ram[4830] = 8'hff; ram[4831] = 8'hff;

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = SZ_B;
    req_uns = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_wen", 64'(mem_wen), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_maddr", mem_addr, 64'd0);
    chk("rst_mwdata", mem_wdata, 64'd0);
    @(posedge clk);
    #1;

    xact(1'b0, SZ_W, 1'b0, 64'd4808, 64'd0, lat, wen_at, wen_n, rd, er);
    chk("lw_s_data", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lw_s_lat", 64'(lat), 64'd2);
    chk("lw_s_err", 64'(er), 64'd0);
    xact(1'b0, SZ_W, 1'b1, 64'd4808, 64'd0, lat, wen_at, wen_n, rd, er);
    chk("lw_u_data", rd, 64'h0000_0000_FFFF_FFFF);

    xact(1'b0, SZ_B, 1'b0, 64'd4828, 64'd0, lat, wen_at, wen_n, rd, er);
    chk("lb_s_data", rd, 64'hFFFF_FFFF_FFFF_FFBA);
    xact(1'b0, SZ_B, 1'b1, 64'd4828, 64'd0, lat, wen_at, wen_n, rd, er);
    chk("lb_u_data", rd, 64'h0000_0000_0000_00BA);
    xact(1'b0, SZ_H, 1'b0, 64'd4828, 64'd0, lat, wen_at, wen_n, rd, er);
    chk("lh_s_data", rd, 64'hFFFF_FFFF_FFFF_FFBA);

    xact(1'b1, SZ_B, 1'b0, 64'd4812, 64'h1234_5678_9ABC_DE7F,
         lat, wen_at, wen_n, rd, er);
    chk("sb_wen_at", 64'(wen_at), 64'd2);
    chk("sb_wen_n", 64'(wen_n), 64'd1);
    chk("sb_lat", 64'(lat), 64'd3);
    chk("sb_rdata", rd, 64'd0);
    xact(1'b0, SZ_D, 1'b0, 64'd4812, 64'd0, lat, wen_at, wen_n, rd, er);
    chk("ld_after_sb", rd, 64'h0000_000A_0000_007F);

    xact(1'b0, SZ_D, 1'b0, 64'd4992, 64'd0, lat, wen_at, wen_n, rd, er);
    chk("ld_4992_err", 64'(er), 64'd0);
    chk("ld_4992_data", rd, 64'd0);
    xact(1'b0, SZ_D, 1'b0, 64'd4993, 64'd0, lat, wen_at, wen_n, rd, er);
    chk("ld_4993_err", 64'(er), 64'd1);
    chk("ld_4993_data", rd, 64'd0);
    chk("ld_4993_lat", 64'(lat), 64'd2);
    xact(1'b1, SZ_W, 1'b0, 64'd4993, 64'hDEAD_BEEF,
         lat, wen_at, wen_n, rd, er);
    chk("st_4993_err", 64'(er), 64'd1);
    chk("st_4993_wen", 64'(wen_n), 64'd0);
    chk("st_4993_lat", 64'(lat), 64'd2);
    xact(1'b0, SZ_B, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0,
         lat, wen_at, wen_n, rd, er);
    chk("ld_huge_err", 64'(er), 64'd1);

    // Half store interrupted by reset in its write cycle.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_H;
    req_uns   = 1'b0;
    req_addr  = 64'd4816;
    req_wdata = 64'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_wen", 64'(mem_wen), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", 64'(req_ready), 64'd1);
    chk("rst_wr_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_wr_byte", 64'(ram[4816]), 64'h0a);
    chk("rst_wr_byte1", 64'(ram[4817]), 64'h00);
    @(posedge clk);
    #1;

    // Held request: loads are accepted every third cycle.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_B;
    req_uns   = 1'b1;
    req_addr  = 64'd4828;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("hold_ready_%0d", i), 64'(req_ready),
          64'((i % 3) == 0));
      chk($sformatf("hold_rvalid_%0d", i), 64'(resp_valid),
          64'((i % 3) == 2));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_end_ready", 64'(req_ready), 64'd1);
    chk("hold_end_rdata", resp_rdata, 64'hBA);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the heap_sort core; sits between the memory stage of the pipeline and `data_ram`. `data_ram` always reads and writes 8 bytes starting at the byte address. This block turns byte, half, word and double loads/stores into that 64-bit access:

- Loads: sign- or zero-extends the read data.
- Sub-double stores: performs a read-modify-write so untouched bytes are preserved.

It also range-checks addresses against the RAM size.

## Interface
Parameters:
- `MEM_BYTES`, 5000: RAM size in bytes; legal access needs `addr + 7 <= MEM_BYTES-1`.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request (IDLE only).
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- `req_unsigned_i`  in  1  zero-extend load (ignored for stores and doubles).
- `req_addr_i`  in  64  byte address.
- `req_wdata_i`  in  64  store data, right-aligned.
- `resp_valid_o`  out  1  one-cycle completion pulse; no backpressure.
- `resp_rdata_o`  out  64  extended load data; 0 for stores and errors.
- `resp_err_o`  out  1  address out of range; valid with `resp_valid_o`.
- `mem_addr_o`  out  64  to `data_ram` address.
- `mem_wdata_o`  out  64  to `data_ram` write data.
- `mem_wen_o`  out  1  to `data_ram` write enable.
- `mem_rdata_i`  in  64  from `data_ram` combinational read data.

## Operation
FSM states are IDLE, ACCESS, WRITE and RESP.

- **IDLE**
  - `req_ready_o = 1`.
  - On `req_valid_i`: latch addr, size, we, unsigned and wdata, then go to ACCESS.
  - Range check: `addr > MEM_BYTES-8`, using a full 64-bit unsigned compare, sets the latched `err` flag.
- **ACCESS**
  - `mem_addr_o` = latched addr.
  - If `err`: go to RESP with rdata = 0 and no memory write.
  - Load: register `extend(mem_rdata_i)`, then go to RESP.
    - Byte: bits [7:0]. Half: [15:0]. Word: [31:0]. Double: [63:0].
    - Sign-extend unless `unsigned`.
  - Store: register the merged word into `wbuf`, then go to WRITE.
    - Byte: `{rdata[63:8], wdata[7:0]}`. Half: `{rdata[63:16], wdata[15:0]}`. Word: `{rdata[63:32], wdata[31:0]}`. Double: `wdata`.
- **WRITE**
  - `mem_wen_o = !rst_i`, `mem_wdata_o = wbuf`.
  - Go to RESP.
- **RESP**
  - `resp_valid_o = 1`.
  - Go to IDLE; a new request is not accepted in this cycle.

Boundaries:
- `req_valid_i` outside IDLE is ignored; the requester must hold it until it sees ready.
- Reset in any state: next state is IDLE.
  - In WRITE, `mem_wen_o` is gated low in the reset cycle, so no partial store occurs.
- A double store still passes through ACCESS, which keeps latency uniform; the read value is discarded.
- Unaligned addresses are legal, since the RAM is byte-addressed; only the range is checked.

## Timing
- Reset values: state IDLE.
  - `req_ready_o = 1`.
  - `resp_valid_o`, `resp_err_o` and `mem_wen_o` = 0.
  - `resp_rdata_o`, `mem_addr_o` and `mem_wdata_o` = 0.
- Request accepted at the edge ending cycle T.
- Load or error: `resp_valid_o` high in cycle T+2.
- Store: `mem_wen_o` high in cycle T+2, the RAM updates at the edge ending T+2, and `resp_valid_o` is high in T+3.
- Throughput: one load per 3 cycles, one store per 4 cycles.
- `mem_addr_o` and `mem_wdata_o` hold their last values outside ACCESS/WRITE.
- `resp_rdata_o` holds its value until the next response.

## Structure
- `lsu_pkg` holds:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`;
  - the FSM state enum;
  - the default `MEM_BYTES`.
- Sub-module `lsu_align` is combinational: load extension and store merge, from `(size, unsigned, rdata, wdata)`.
- `lsu` holds the FSM, request latches and range check.

## Test plan
RAM preloaded: bytes 4808..4811 = ff ff ff ff, 4812 = 32, 4816 = 0a, 4828 = ba ff ff ff; other bytes 0.
1. Word load 4808, signed → rdata `0xFFFFFFFFFFFFFFFF`. Unsigned → `0x00000000FFFFFFFF`. `resp_valid_o` at T+2.
2. Byte load 4828, signed → `0xFFFFFFFFFFFFFFBA`. Unsigned → `0x00000000000000BA`.
3. Byte store `0x7F` to 4812, then double load 4812 → `0x0000000A0000007F`; `mem_wen_o` high only in T+2.
4. Double load 4992 → ok, err = 0. Load or store at 4993 → err = 1, rdata = 0, `mem_wen_o` never asserts.
5. Half store `0xBEEF` to 4816 with `rst_i` asserted in the WRITE cycle → `mem_wen_o` stays 0, byte 4816 still `0a`, FSM in IDLE next cycle.
6. `req_valid_i` held continuously with back-to-back requests → accepted only in IDLE cycles; `req_ready_o` low in ACCESS/WRITE/RESP.
